// File: rtl/ahbl_sram64_slave.sv
// AHB-Lite slave for a 64-bit single-port SRAM. Zero wait states; each write is
// parked in a one-entry buffer and retired on the first cycle the port is free of reads.
module ahbl_sram64_slave #(
  parameter int ADDR_W = 10
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [63:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [63:0]       HRDATA,
  input  logic [63:0]       SRAMRDATA,
  output logic [7:0]        SRAMWEN,
  output logic [63:0]       SRAMWDATA,
  output logic              SRAMCS0,
  output logic [ADDR_W-1:0] SRAMADDR
);

  logic              w_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_drain;
  logic [ADDR_W-1:0] w_word_addr;
  logic [7:0]        w_mask;
  logic [63:0]       w_rdata;
  logic              w_unused_bits;

  logic              r_rd_phase;
  logic              r_wr_phase;
  logic [ADDR_W-1:0] r_ph_addr;
  logic [7:0]        r_ph_mask;

  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [7:0]        r_buf_mask;
  logic [63:0]       r_buf_data;

  // Gating with HRESETn keeps the SRAM port quiet while reset is held.
  assign w_acc       = HSEL & HTRANS[1] & HREADY & HRESETn;
  assign w_rd_acc    = w_acc & ~HWRITE;
  assign w_wr_acc    = w_acc & HWRITE;
  assign w_word_addr = HADDR[ADDR_W+2:3];
  assign w_drain     = r_buf_valid & ~w_rd_acc;
  assign w_unused_bits = ^{HTRANS[0], HADDR[31:ADDR_W+3]};

  always_comb begin
    w_mask = 8'hFF;
    case (HSIZE)
      3'd0:    w_mask = 8'h01 << HADDR[2:0];
      3'd1:    w_mask = 8'h03 << {HADDR[2:1], 1'b0};
      3'd2:    w_mask = 8'h0F << {HADDR[2], 2'b00};
      default: w_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rd_phase <= 1'b0;
      r_wr_phase <= 1'b0;
      r_ph_addr  <= '0;
      r_ph_mask  <= '0;
    end else if (HREADY) begin
      r_rd_phase <= w_rd_acc;
      r_wr_phase <= w_wr_acc;
      if (w_acc) begin
        r_ph_addr <= w_word_addr;
        r_ph_mask <= w_mask;
      end
    end
  end

  // A load on the same edge as a drain overrides the clear: newest write wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_mask  <= '0;
      r_buf_data  <= '0;
    end else if (r_wr_phase && HREADY) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_ph_addr;
      r_buf_mask  <= r_ph_mask;
      r_buf_data  <= HWDATA;
    end else if (w_drain) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Read data is the SRAM word overlaid with any still-buffered bytes of that word.
  always_comb begin
    w_rdata = 64'd0;
    if (r_rd_phase) begin
      w_rdata = SRAMRDATA;
      if (r_buf_valid && (r_buf_addr == r_ph_addr)) begin
        for (int b = 0; b < 8; b++) begin
          if (r_buf_mask[b]) w_rdata[b*8 +: 8] = r_buf_data[b*8 +: 8];
        end
      end
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign HRDATA    = w_rdata;
  assign SRAMCS0   = w_rd_acc | r_buf_valid;
  assign SRAMWEN   = w_drain ? r_buf_mask : 8'h00;
  assign SRAMADDR  = w_rd_acc ? w_word_addr : r_buf_addr;
  assign SRAMWDATA = r_buf_data;

endmodule

// File: tb/tb_ahbl_sram64_slave.sv
// Directed bench for ahbl_sram64_slave: behavioural SRAM, hand-computed expectations.
module tb_ahbl_sram64_slave;
  localparam int ADDR_W = 10;

  logic              HCLK;
  logic              HRESETn;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic              HREADY;
  logic [63:0]       HWDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [63:0]       HRDATA;
  logic [63:0]       SRAMRDATA;
  logic [7:0]        SRAMWEN;
  logic [63:0]       SRAMWDATA;
  logic              SRAMCS0;
  logic [ADDR_W-1:0] SRAMADDR;

  logic [63:0] mem [0:(1<<ADDR_W)-1];
  logic        tb_init;
  int          n_checks = 0;
  int          n_fail   = 0;

  ahbl_sram64_slave #(.ADDR_W(ADDR_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAMRDATA(SRAMRDATA), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
    .SRAMCS0(SRAMCS0), .SRAMADDR(SRAMADDR)
  );

  // clock
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // SRAM model: word i is preloaded with byte value (i % 256) in every lane
  always @(posedge HCLK) begin
    if (tb_init) begin
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] <= 64'(i % 256) * 64'h0101010101010101;
    end else if (SRAMCS0) begin
      if (SRAMWEN == 8'd0) SRAMRDATA <= mem[SRAMADDR];
      else begin
        for (int b = 0; b < 8; b++)
          if (SRAMWEN[b]) mem[SRAMADDR][b*8 +: 8] <= SRAMWDATA[b*8 +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic nc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic drive_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1; HWRITE = wr; HADDR = addr; HSIZE = size;
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; HWRITE = 1'b0; HADDR = 32'd0; HSIZE = 3'd0;
  endtask

  task automatic check_drain(input string tag, input logic [7:0] wen, input logic [9:0] waddr,
                             input logic [63:0] wdata);
    check_eq({tag, "_cs"},    64'(SRAMCS0),   64'd1);
    check_eq({tag, "_wen"},   64'(SRAMWEN),   64'(wen));
    check_eq({tag, "_addr"},  64'(SRAMADDR),  64'(waddr));
    check_eq({tag, "_wdata"}, SRAMWDATA,      wdata);
  endtask

  task automatic read_word(input string tag, input logic [31:0] addr, input logic [9:0] waddr,
                           input logic [63:0] exp);
    drive_xfer(1'b0, addr, 3'd3);
    mid();
    check_eq({tag, "_cs"},   64'(SRAMCS0),  64'd1);
    check_eq({tag, "_wen"},  64'(SRAMWEN),  64'd0);
    check_eq({tag, "_addr"}, 64'(SRAMADDR), 64'(waddr));
    nc();
    drive_idle();
    mid();
    check_eq({tag, "_data"}, HRDATA, exp);
    nc();
  endtask

  initial begin
    tb_init = 1'b1;
    HRESETn = 1'b0;
    HWDATA  = 64'd0;
    drive_xfer(1'b0, 32'h10, 3'd3);
    mid();
    check_eq("rst_readyout", 64'(HREADYOUT), 64'd1);
    check_eq("rst_resp",     64'(HRESP),     64'd0);
    check_eq("rst_rdata",    HRDATA,         64'd0);
    check_eq("rst_cs",       64'(SRAMCS0),   64'd0);
    check_eq("rst_wen",      64'(SRAMWEN),   64'd0);
    check_eq("rst_wdata",    SRAMWDATA,      64'd0);
    check_eq("rst_addr",     64'(SRAMADDR),  64'd0);
    nc();
    tb_init = 1'b0;
    nc();
    HRESETn = 1'b1;
    drive_idle();
    mid();
    check_eq("idle_cs", 64'(SRAMCS0), 64'd0);
    check_eq("idle_rdata", HRDATA, 64'd0);
    nc();

    // full-word write then idle: drain to word 2, then readback
    drive_xfer(1'b1, 32'h10, 3'd3);
    mid();
    check_eq("t1_addr_cs", 64'(SRAMCS0), 64'd0);
    nc();
    drive_idle();
    HWDATA = 64'h1122334455667788;
    mid();
    check_eq("t1_data_cs", 64'(SRAMCS0), 64'd0);
    check_eq("t1_data_rdata", HRDATA, 64'd0);
    nc();
    mid();
    check_drain("t1_drain", 8'hFF, 10'd2, 64'h1122334455667788);
    nc();
    mid();
    check_eq("t1_after_cs", 64'(SRAMCS0), 64'd0);
    nc();
    read_word("t1_rd", 32'h10, 10'd2, 64'h1122334455667788);

    // byte write to lane 3, immediately followed by a read of the same word
    drive_xfer(1'b1, 32'h13, 3'd0);
    nc();
    drive_xfer(1'b0, 32'h10, 3'd3);
    HWDATA = 64'h00000000AB000000;
    mid();
    check_eq("t2_rd_cs",   64'(SRAMCS0),   64'd1);
    check_eq("t2_rd_wen",  64'(SRAMWEN),   64'd0);
    check_eq("t2_rd_addr", 64'(SRAMADDR),  64'd2);
    check_eq("t2_rdy_a",   64'(HREADYOUT), 64'd1);
    nc();
    drive_idle();
    mid();
    check_eq("t2_merge", HRDATA, 64'h11223344AB667788);
    check_eq("t2_rdy_d", 64'(HREADYOUT), 64'd1);
    check_eq("t2_drain_wen",  64'(SRAMWEN),  64'h08);
    check_eq("t2_drain_addr", 64'(SRAMADDR), 64'd2);
    nc();
    read_word("t2_rd", 32'h10, 10'd2, 64'h11223344AB667788);

    // word-size-2 write to 0x08 held off by five reads of 0x40
    drive_xfer(1'b1, 32'h08, 3'd2);
    nc();
    HWDATA = 64'hDEADBEEFCAFEF00D;
    for (int k = 0; k < 5; k++) begin
      drive_xfer(1'b0, 32'h40, 3'd3);
      mid();
      check_eq($sformatf("t3_rd%0d_wen", k),  64'(SRAMWEN),  64'd0);
      check_eq($sformatf("t3_rd%0d_addr", k), 64'(SRAMADDR), 64'd8);
      if (k > 0) check_eq($sformatf("t3_rd%0d_data", k), HRDATA, 64'h0808080808080808);
      nc();
    end
    drive_idle();
    mid();
    check_eq("t3_rd4_data", HRDATA, 64'h0808080808080808);
    check_drain("t3_drain", 8'h0F, 10'd1, 64'hDEADBEEFCAFEF00D);
    nc();
    read_word("t3_rd", 32'h08, 10'd1, 64'h01010101CAFEF00D);

    // back-to-back writes A (word 3) then B (word 4)
    drive_xfer(1'b1, 32'h18, 3'd3);
    nc();
    drive_xfer(1'b1, 32'h20, 3'd3);
    HWDATA = 64'hAAAAAAAAAAAAAAAA;
    mid();
    check_eq("t4_b_addr_cs", 64'(SRAMCS0), 64'd0);
    nc();
    drive_idle();
    HWDATA = 64'hBBBBBBBBBBBBBBBB;
    mid();
    check_drain("t4_drain_a", 8'hFF, 10'd3, 64'hAAAAAAAAAAAAAAAA);
    nc();
    mid();
    check_drain("t4_drain_b", 8'hFF, 10'd4, 64'hBBBBBBBBBBBBBBBB);
    nc();
    mid();
    check_eq("t4_after_cs", 64'(SRAMCS0), 64'd0);
    nc();
    read_word("t4_rd_a", 32'h18, 10'd3, 64'hAAAAAAAAAAAAAAAA);
    read_word("t4_rd_b", 32'h20, 10'd4, 64'hBBBBBBBBBBBBBBBB);

    // halfword at 0x26 -> lanes 6-7 of word 4
    drive_xfer(1'b1, 32'h26, 3'd1);
    nc();
    drive_idle();
    HWDATA = 64'h1234000000000000;
    nc();
    mid();
    check_drain("t5_drain", 8'hC0, 10'd4, 64'h1234000000000000);
    nc();
    read_word("t5_rd", 32'h20, 10'd4, 64'h1234BBBBBBBBBBBB);

    // misaligned size-2 at 0x0D -> lanes 4-7 of word 1
    drive_xfer(1'b1, 32'h0D, 3'd2);
    nc();
    drive_idle();
    HWDATA = 64'h7766554400000000;
    nc();
    mid();
    check_drain("t6_drain", 8'hF0, 10'd1, 64'h7766554400000000);
    nc();

    // reset with a pending write: it must be discarded
    drive_xfer(1'b1, 32'h30, 3'd3);
    nc();
    drive_idle();
    HWDATA = 64'hFFFFFFFFFFFFFFFF;
    nc();
    HRESETn = 1'b0;
    drive_xfer(1'b0, 32'h10, 3'd3);
    mid();
    check_eq("t7_rst_cs",    64'(SRAMCS0),   64'd0);
    check_eq("t7_rst_wen",   64'(SRAMWEN),   64'd0);
    check_eq("t7_rst_addr",  64'(SRAMADDR),  64'd0);
    check_eq("t7_rst_wdata", SRAMWDATA,      64'd0);
    check_eq("t7_rst_rdata", HRDATA,         64'd0);
    check_eq("t7_rst_rdy",   64'(HREADYOUT), 64'd1);
    check_eq("t7_rst_resp",  64'(HRESP),     64'd0);
    nc();
    HRESETn = 1'b1;
    drive_idle();
    mid();
    check_eq("t7_post_cs", 64'(SRAMCS0), 64'd0);
    nc();
    read_word("t7_rd", 32'h30, 10'd6, 64'h0606060606060606);

    // BUSY, unselected, and HREADY-low transfers are ignored
    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b0; HADDR = 32'h10; HSIZE = 3'd3;
    mid();
    check_eq("t8_busy_cs", 64'(SRAMCS0), 64'd0);
    nc();
    HSEL = 1'b0; HTRANS = 2'b10;
    mid();
    check_eq("t8_busy_rdata", HRDATA, 64'd0);
    check_eq("t8_nosel_cs", 64'(SRAMCS0), 64'd0);
    nc();
    HSEL = 1'b1; HREADY = 1'b0;
    mid();
    check_eq("t8_nordy_cs", 64'(SRAMCS0), 64'd0);
    nc();
    drive_idle();
    mid();
    check_eq("t8_nordy_rdata", HRDATA, 64'd0);
    nc();

    // high address bits alias onto word 2
    read_word("t9_alias", 32'h1000_0010, 10'd2, 64'h11223344AB667788);
    read_word("t9_word1", 32'h08, 10'd1, 64'h77665544CAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
